// File: rtl/md_unit_pkg.sv
// Shared MDOp encodings and classification helpers for the multiply/divide unit.
// Pure definitions: no logic, no latency.
// The E-stage decoder and md_unit both take these values from here.
package md_unit_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_NONE  = 3'b000;
  localparam md_op_t MD_MULT  = 3'b001;
  localparam md_op_t MD_MULTU = 3'b010;
  localparam md_op_t MD_DIV   = 3'b011;
  localparam md_op_t MD_DIVU  = 3'b100;
  localparam md_op_t MD_MTHI  = 3'b101;
  localparam md_op_t MD_MTLO  = 3'b110;
  localparam md_op_t MD_MADD  = 3'b111;

  // Multi-cycle operations: these raise start and run the busy counter.
  function automatic logic md_is_long(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MADD);
  endfunction

  // Divide-class operations use the longer latency.
  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; results computed at start, committed after N busy cycles.
// Latency: MULT_CYCLES for mult/multu/madd, DIV_CYCLES for div/divu, 0 for mthi/mtlo.
// Backpressure: busy stalls upstream; new long ops or moves presented while busy are ignored.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  MDOp,
  input  logic        HILOSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HILO_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // Committed architectural registers.
  logic [31:0]   hi;
  logic [31:0]   lo;

  // Result captured at start, held until the counter expires.
  logic [31:0]   hi_tmp;
  logic [31:0]   lo_tmp;
  logic          discard;   // divide by zero: run the latency but never commit
  logic [CW-1:0] cnt;

  // Next-state values for the capture registers, valid only when start is high.
  logic [31:0]   nxt_hi;
  logic [31:0]   nxt_lo;
  logic [CW-1:0] nxt_cnt;
  logic          nxt_discard;

  logic [63:0]   sprod;
  logic [63:0]   uprod;
  logic [63:0]   acc;

  assign busy     = (cnt != '0);
  assign start    = md_is_long(md_op_t'(MDOp)) & ~busy & ~req;
  assign HILO_out = HILOSel ? lo : hi;

  // Compute the result of the operation being started and its latency.
  always_comb begin
    sprod       = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    uprod       = {32'b0, A} * {32'b0, B};
    acc         = {hi, lo} + sprod;
    nxt_hi      = '0;
    nxt_lo      = '0;
    nxt_discard = 1'b0;
    nxt_cnt     = md_is_div(md_op_t'(MDOp)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    case (MDOp)
      MD_MULT: begin
        nxt_hi = sprod[63:32];
        nxt_lo = sprod[31:0];
      end
      MD_MULTU: begin
        nxt_hi = uprod[63:32];
        nxt_lo = uprod[31:0];
      end
      MD_MADD: begin
        nxt_hi = acc[63:32];
        nxt_lo = acc[31:0];
      end
      MD_DIV: begin
        if (B == '0) begin
          nxt_discard = 1'b1;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // The only signed overflow case: quotient wraps, remainder is zero.
          nxt_lo = 32'h8000_0000;
          nxt_hi = '0;
        end else begin
          nxt_lo = $signed(A) / $signed(B);
          nxt_hi = $signed(A) % $signed(B);
        end
      end
      MD_DIVU: begin
        if (B == '0) begin
          nxt_discard = 1'b1;
        end else begin
          nxt_lo = A / B;
          nxt_hi = A % B;
        end
      end
      default: begin
        nxt_hi = '0;
        nxt_lo = '0;
      end
    endcase
  end

  // Capture on start, count down while busy, commit on the last busy cycle, apply idle moves.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi      <= '0;
      lo      <= '0;
      hi_tmp  <= '0;
      lo_tmp  <= '0;
      discard <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      hi_tmp  <= nxt_hi;
      lo_tmp  <= nxt_lo;
      discard <= nxt_discard;
      cnt     <= nxt_cnt;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && !discard) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
      end
    end else if (!req) begin
      if (MDOp == MD_MTHI) hi <= A;
      if (MDOp == MD_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic, divide-by-zero, flush and reset cases.
// Inputs change 1ns after posedge; outputs are sampled before the next posedge.
// Expected values are hand-computed constants.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  MDOp;
  logic        HILOSel;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] HILO_out;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .MDOp     (MDOp),
    .HILOSel  (HILOSel),
    .A        (A),
    .B        (B),
    .req      (req),
    .start    (start),
    .busy     (busy),
    .HILO_out (HILO_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    HILOSel = 1'b0;
    #1;
    chk({tag, "_hi"}, HILO_out, exp_hi);
    HILOSel = 1'b1;
    #1;
    chk({tag, "_lo"}, HILO_out, exp_lo);
  endtask

  task automatic idle();
    MDOp = MD_NONE;
    A    = '0;
    B    = '0;
    req  = 1'b0;
  endtask

  // Issue a long op, then hold busy_op/busy_a/busy_req during the busy window.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [2:0] busy_op, input logic [31:0] busy_a,
                        input logic busy_req);
    int busy_cycles;
    MDOp = op;
    A    = a;
    B    = b;
    req  = 1'b0;
    #1;
    chk({tag, "_start"}, {31'b0, start}, 32'd1);
    step();
    busy_cycles = 0;
    for (int k = 1; k <= n; k++) begin
      MDOp = busy_op;
      A    = busy_a;
      req  = busy_req;
      #1;
      if (busy === 1'b1) busy_cycles++;
      chk({tag, "_nostart_busy"}, {31'b0, start}, 32'd0);
      if (k == n) chk_hilo({tag, "_uncommitted"}, old_hi, old_lo);
      step();
    end
    chk({tag, "_busy_cycles"}, busy_cycles, n);
    idle();
    #1;
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    chk_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    HILOSel = 1'b0;
    idle();
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_start", {31'b0, start}, 32'd0);
    chk_hilo("reset", 32'h0, 32'h0);
    step();

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'h0, 32'h0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, MD_MULT, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           32'd2, 32'd14, MD_DIVU, 32'd100, 1'b0);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'd2, 32'd14,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, MD_DIV, 32'hFFFF_FFF9, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd1, 32'hFFFF_FFFE, MD_MULTU, 32'hFFFF_FFFF, 1'b0);

    // Moves take effect at the end of their own cycle and never raise start.
    MDOp = MD_MTHI;
    A    = 32'h11;
    #1;
    chk("mthi_start", {31'b0, start}, 32'd0);
    step();
    MDOp = MD_MTLO;
    A    = 32'h22;
    step();
    idle();
    chk_hilo("mthi_mtlo", 32'h11, 32'h22);

    // Divide by zero keeps HI/LO; an mtlo slipped in during busy is dropped too.
    run_op("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22,
           32'h11, 32'h22, MD_MTLO, 32'h0BAD, 1'b0);

    MDOp = MD_MTHI;
    A    = 32'h0;
    step();
    MDOp = MD_MTLO;
    A    = 32'hFFFF_FFFF;
    step();
    idle();
    run_op("madd_carry", MD_MADD, 32'd1, 32'd1, 5, 32'h0, 32'hFFFF_FFFF,
           32'd1, 32'd0, MD_MADD, 32'd1, 1'b0);
    run_op("madd_neg", MD_MADD, 32'hFFFF_FFFF, 32'd1, 5, 32'd1, 32'd0,
           32'd0, 32'hFFFF_FFFF, MD_MADD, 32'hFFFF_FFFF, 1'b0);

    // Flushed mtlo has no effect; the same mtlo without flush lands next cycle.
    MDOp = MD_MTLO;
    A    = 32'hDEAD;
    req  = 1'b1;
    step();
    req = 1'b0;
    MDOp = MD_NONE;
    chk_hilo("mtlo_flushed", 32'd0, 32'hFFFF_FFFF);
    MDOp = MD_MTLO;
    A    = 32'hDEAD;
    step();
    idle();
    chk_hilo("mtlo", 32'd0, 32'h0000_DEAD);

    // Flushed mult never starts.
    MDOp = MD_MULT;
    A    = 32'd3;
    B    = 32'd3;
    req  = 1'b1;
    #1;
    chk("mult_flushed_start", {31'b0, start}, 32'd0);
    step();
    idle();
    #1;
    chk("mult_flushed_busy", {31'b0, busy}, 32'd0);
    chk_hilo("mult_flushed", 32'd0, 32'h0000_DEAD);

    // A flush arriving while busy does not disturb the older in-flight op.
    run_op("mult_req_busy", MD_MULT, 32'd2, 32'd3, 5, 32'd0, 32'h0000_DEAD,
           32'd0, 32'd6, MD_MULT, 32'd2, 1'b1);

    // Reset in the middle of a mult discards the pending result.
    MDOp = MD_MULT;
    A    = 32'd5;
    B    = 32'd5;
    step();
    idle();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk_hilo("rst_mid", 32'd0, 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("rst_mid_late_busy", {31'b0, busy}, 32'd0);
    chk_hilo("rst_mid_late", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
